argmax_8_16: RTL and testbench



---
 rtl/nn_pkg.sv | 13 +
 rtl/argmax_8_16.sv | 91 +++++++++
 tb/tb_argmax_8_16.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared datapath definitions for the layer and argmax classifier stages.
package nn_pkg;

    localparam int T = 16;

    typedef logic signed [T-1:0] data_t;

    // Index width for n entries; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/argmax_8_16.sv
// Streaming argmax: consumes N signed words per vector and emits the index and
// value of the largest one, ties resolved toward the lower index.
module argmax_8_16
    import nn_pkg::*;
#(
    parameter int N  = 8,
    parameter int TW = nn_pkg::T,
    localparam int IW = idx_w(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    input  logic                 m_ready,
    input  logic signed [TW-1:0] data_in,
    output logic                 m_valid,
    output logic                 s_ready,
    output logic [IW-1:0]        idx_out,
    output logic signed [TW-1:0] max_out
);

    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [IW-1:0]        cnt_q, cnt_d;
    logic signed [TW-1:0] cur_max_q, cur_max_d;
    logic [IW-1:0]        cur_idx_q, cur_idx_d;
    logic                 m_valid_q, m_valid_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic signed [TW-1:0] max_q, max_d;

    logic                 accept, is_last;
    logic signed [TW-1:0] nxt_max;
    logic [IW-1:0]        nxt_idx;

    always_comb begin
        is_last = (cnt_q == LAST);
        // Only the final word can overwrite the output register, so only it waits.
        s_ready = !is_last || !m_valid_q || m_ready;
        accept  = s_valid && s_ready;

        nxt_max = cur_max_q;
        nxt_idx = cur_idx_q;
        if (cnt_q == '0) begin
            nxt_max = data_in;
            nxt_idx = '0;
        end else if (data_in > cur_max_q) begin
            nxt_max = data_in;
            nxt_idx = cnt_q;
        end

        cnt_d     = cnt_q;
        cur_max_d = cur_max_q;
        cur_idx_d = cur_idx_q;
        idx_d     = idx_q;
        max_d     = max_q;
        m_valid_d = m_valid_q && !m_ready;

        if (accept) begin
            cur_max_d = nxt_max;
            cur_idx_d = nxt_idx;
            cnt_d     = is_last ? '0 : cnt_q + 1'b1;
            if (is_last) begin
                idx_d     = nxt_idx;
                max_d     = nxt_max;
                m_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            cur_max_q <= '0;
            cur_idx_q <= '0;
            m_valid_q <= 1'b0;
            idx_q     <= '0;
            max_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            cur_max_q <= cur_max_d;
            cur_idx_q <= cur_idx_d;
            m_valid_q <= m_valid_d;
            idx_q     <= idx_d;
            max_q     <= max_d;
        end
    end

    assign m_valid = m_valid_q;
    assign idx_out = idx_q;
    assign max_out = max_q;

endmodule

// File: tb/tb_argmax_8_16.sv
// Scoreboard bench for argmax_8_16: expected {idx,max} queued per vector sent,
// popped by a monitor on every result transfer.
module tb_argmax_8_16;

    typedef struct packed {
        logic [2:0]         idx;
        logic signed [15:0] mx;
    } res_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               s_valid = 1'b0;
    logic               m_ready = 1'b0;
    logic signed [15:0] data_in = '0;
    logic               m_valid, s_ready;
    logic [2:0]         idx_out;
    logic signed [15:0] max_out;

    int   checks = 0;
    int   errors = 0;
    res_t sb[$];
    bit   rand_en = 1'b0;
    int   stalls;

    argmax_8_16 dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .m_ready(m_ready),
        .data_in(data_in), .m_valid(m_valid), .s_ready(s_ready),
        .idx_out(idx_out), .max_out(max_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rand_en) begin
        #1 m_ready = ($urandom_range(0, 3) != 0);
    end

    // Result monitor: every cycle with m_valid the output must equal the queue head.
    always @(negedge clk) if (!reset && m_valid) begin
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result got idx=%0d max=%0d, scoreboard empty", idx_out, max_out);
        end else begin
            if (idx_out !== sb[0].idx || max_out !== sb[0].mx) begin
                errors++;
                $display("FAIL result got idx=%0d max=%0d exp idx=%0d max=%0d",
                         idx_out, max_out, sb[0].idx, sb[0].mx);
            end
            if (m_ready) void'(sb.pop_front());
        end
    end

    function automatic res_t model(input int v[8]);
        res_t r;
        int   best = v[0];
        int   bi = 0;
        for (int i = 1; i < 8; i++) if (v[i] > best) begin best = v[i]; bi = i; end
        r.idx = 3'(bi);
        r.mx  = 16'(best);
        return r;
    endfunction

    // Present one word and hold it until accepted; counts stall cycles.
    task automatic send_word(input int v, input int gap);
        bit got;
        int n = 0;
        for (int g = 0; g < gap; g++) begin s_valid = 1'b0; @(posedge clk); #1; end
        s_valid = 1'b1;
        data_in = 16'(v);
        got = 1'b0;
        while (!got && n < 500) begin
            @(negedge clk);
            got = s_ready;
            if (!got) stalls++;
            @(posedge clk); #1;
            n++;
        end
        s_valid = 1'b0;
        data_in = 'x;
        if (!got) begin
            checks++; errors++;
            $display("FAIL accept_timeout word=%0d not accepted in 500 cycles", v);
        end
    endtask

    task automatic send_vec(input int v[8], input int first, input int last, input bit push);
        if (push) sb.push_back(model(v));
        for (int i = first; i <= last; i++) send_word(v[i], 0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin @(posedge clk); #1; n++; end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending, exp 0", sb.size());
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (m_valid !== 1'b0 || idx_out !== 3'd0 || max_out !== 16'sd0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s got m_valid=%b idx=%0d max=%0d s_ready=%b exp 0 0 0 1",
                     name, m_valid, idx_out, max_out, s_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_state");
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int v[8] = '{3, -1, 7, 2, 7, 0, -5, 1};
        m_ready = 1'b1;
        send_vec(v, 0, 7, 1'b1);
        // Result must be visible the cycle right after the 8th accept edge.
        checks++;
        if (m_valid !== 1'b1 || idx_out !== 3'd2 || max_out !== 16'sd7) begin
            errors++;
            $display("FAIL basic_latency got v=%b idx=%0d max=%0d exp 1 2 7", m_valid, idx_out, max_out);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int a[8] = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
        int b[8] = '{0, 0, 0, 0, 0, 0, 0, 100};
        m_ready = 1'b1;
        stalls = 0;
        send_vec(a, 0, 7, 1'b1);
        send_vec(b, 0, 7, 1'b1);
        checks++;
        if (stalls != 0) begin
            errors++;
            $display("FAIL back_to_back_stalls got %0d exp 0", stalls);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        int a[8] = '{5, 4, 3, 2, 1, 0, -1, 6};
        int b[8] = '{-9, -8, -7, -3, -7, -3, -10, -20};
        m_ready = 1'b0;
        send_vec(a, 0, 7, 1'b1);
        stalls = 0;
        send_vec(b, 0, 6, 1'b1);
        checks++;
        if (stalls != 0) begin
            errors++;
            $display("FAIL bp_first7_stalls got %0d exp 0", stalls);
        end
        s_valid = 1'b1;
        data_in = 16'(b[7]);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (s_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_s_ready_stall got %b exp 0", s_ready);
            end
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_same_cycle();
        int a[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
        int b[8] = '{-1, 200, 3, 200, 5, 6, 7, 8};
        m_ready = 1'b0;
        send_vec(a, 0, 7, 1'b1);
        send_vec(b, 0, 6, 1'b1);
        m_ready = 1'b1;
        send_word(b[7], 0);
        checks++;
        if (m_valid !== 1'b1 || idx_out !== 3'd1 || max_out !== 16'sd200) begin
            errors++;
            $display("FAIL same_cycle got v=%b idx=%0d max=%0d exp 1 1 200", m_valid, idx_out, max_out);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid();
        int p[8] = '{10, 20, 30, 40, 50, 60, 70, 80};
        int v[8] = '{9, 1, 1, 1, 1, 1, 1, 1};
        m_ready = 1'b0;
        send_vec(p, 0, 7, 1'b1);
        send_vec(p, 0, 3, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        check_idle_outputs("reset_mid");
        reset = 1'b0;
        m_ready = 1'b1;
        send_vec(v, 0, 7, 1'b1);
        checks++;
        if (m_valid !== 1'b1 || idx_out !== 3'd0 || max_out !== 16'sd9) begin
            errors++;
            $display("FAIL after_reset got v=%b idx=%0d max=%0d exp 1 0 9", m_valid, idx_out, max_out);
        end
        wait_drain();
    endtask

    task automatic test_random();
        int v[8];
        rand_en = 1'b1;
        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < 8; i++)
                v[i] = (k % 2) ? int'($urandom_range(0, 7)) - 4 : int'($urandom_range(0, 65535)) - 32768;
            sb.push_back(model(v));
            for (int i = 0; i < 8; i++) send_word(v[i], int'($urandom_range(0, 3) == 0));
        end
        rand_en = 1'b0;
        @(posedge clk); #2;
        m_ready = 1'b1;
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_same_cycle();
        test_reset_mid();
        test_random();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
